// File: rtl/fg_config_loader.sv
// -----------------------------------------------------------------------------
// fg_config_loader
//
// Serial configuration writer for the function generator. A mode-0 SPI-style
// link (sclk idles low, data sampled on the rising edge, MSB first) delivers a
// configuration word. The word is published on CR_bus_o in a single clock
// cycle, so the generator never observes a partially written word. While a
// frame is being shifted in, the currently active word is shifted back out on
// spi_miso_o as readback.
//
// Ports
//   clk_i             system clock
//   rstn_i            synchronous reset, active low
//   spi_sclk_i        serial clock, asynchronous to clk_i, idles low
//   spi_cs_n_i        frame select, active low
//   spi_mosi_i        serial data in, MSB first
//   spi_miso_o        readback data out, MSB first (0 outside a frame)
//   CR_bus_o          active configuration word
//   cr_update_strb_o  1-cycle pulse when CR_bus_o takes a new value
//   frame_error_o     1-cycle pulse when a short or overrun frame is discarded
// -----------------------------------------------------------------------------
module fg_config_loader #(
  parameter int unsigned                         CONFIG_REG_BITWIDTH = 64,
  parameter logic [CONFIG_REG_BITWIDTH-1:0]      CR_RESET_VALUE      = '0,
  parameter int unsigned                         SYNC_STAGES         = 2
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           spi_sclk_i,
  input  logic                           spi_cs_n_i,
  input  logic                           spi_mosi_i,
  output logic                           spi_miso_o,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           cr_update_strb_o,
  output logic                           frame_error_o
);

  localparam int unsigned W     = CONFIG_REG_BITWIDTH;
  // The counter must hold W+1 so that an overrun is distinguishable from a
  // complete frame.
  localparam int unsigned CNT_W = $clog2(W + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge-detect history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n_i};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_rise   =  cs_s   & ~cs_prev_q;
  assign cs_fall   = ~cs_s   &  cs_prev_q;

  // ---------------------------------------------------------------------------
  // FSM, shift registers and output registers
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [W-1:0]     wr_shift_q, wr_shift_d;
  logic [W-1:0]     rd_shift_q, rd_shift_d;
  logic [W-1:0]     cr_q,       cr_d;
  logic             strb_q,     strb_d;
  logic             err_q,      err_d;
  logic             miso_q,     miso_d;

  // NOTE: every *_d gets its hold value first, so no path through the case
  // statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wr_shift_d = wr_shift_q;
    rd_shift_d = rd_shift_q;
    cr_d       = cr_q;
    strb_d     = 1'b0;
    err_d      = 1'b0;
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          rd_shift_d = cr_q;
          bit_cnt_d  = '0;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // End of frame takes priority; a coincident sclk edge is dropped
          // and the bit count stays frozen.
          state_d = ST_COMMIT;
        end else begin
          if (sclk_rise) begin
            wr_shift_d = {wr_shift_q[W-2:0], mosi_s};
            if (bit_cnt_q != CNT_OVR) begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end
          if (sclk_fall) begin
            rd_shift_d = {rd_shift_q[W-2:0], 1'b0};
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        // Hold the cs_n history so a falling edge arriving in this cycle is
        // still seen as an edge in the following IDLE cycle.
        cs_prev_d = cs_prev_q;
        if (bit_cnt_q == CNT_FULL) begin
          cr_d   = wr_shift_q;
          strb_d = 1'b1;
        end else if (bit_cnt_q != '0) begin
          // Short frame (1..W-1 bits) or overrun (W+1 saturated).
          err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered readback: the MSB of the readback register is presented as
    // soon as SHIFT is entered, ahead of the first sclk rising edge.
    miso_d = (state_d == ST_SHIFT) ? rd_shift_d[W-1] : 1'b0;
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      // NOTE: the shift registers are data-path storage, yet they are cleared
      // here too so readback and commit never expose stale words after reset.
      // cs_n history resets to the idle (high) level so releasing reset never
      // fabricates a frame start.
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      wr_shift_q  <= '0;
      rd_shift_q  <= '0;
      cr_q        <= CR_RESET_VALUE;
      strb_q      <= 1'b0;
      err_q       <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_shift_q  <= wr_shift_d;
      rd_shift_q  <= rd_shift_d;
      cr_q        <= cr_d;
      strb_q      <= strb_d;
      err_q       <= err_d;
      miso_q      <= miso_d;
    end
  end

  assign CR_bus_o         = cr_q;
  assign cr_update_strb_o = strb_q;
  assign frame_error_o    = err_q;
  assign spi_miso_o       = miso_q;

endmodule

// File: tb/tb_fg_config_loader.sv
// -----------------------------------------------------------------------------
// tb_fg_config_loader
//
// Drives directed SPI frames into fg_config_loader. Each frame pushes the
// response it must produce (commit strobe with new word, or error pulse with
// the unchanged word) into a queue; an independent monitor pops and compares
// whenever the DUT pulses either output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fg_config_loader;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sclk, cs_n, mosi;
  logic        miso;
  logic [63:0] cr;
  logic        strb, err;

  always #5 clk = ~clk;

  fg_config_loader #(
    .CONFIG_REG_BITWIDTH(64),
    .CR_RESET_VALUE     (64'h0),
    .SYNC_STAGES        (SYNC)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .spi_sclk_i      (sclk),
    .spi_cs_n_i      (cs_n),
    .spi_mosi_i      (mosi),
    .spi_miso_o      (miso),
    .CR_bus_o        (cr),
    .cr_update_strb_o(strb),
    .frame_error_o   (err)
  );

  typedef enum logic {EV_STRB, EV_ERR} ev_e;
  typedef struct {
    ev_e         kind;
    logic [63:0] cr;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          passes = 0;
  logic [63:0] cr_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every pulse on either output must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (strb === 1'b1 || err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {62'b0, strb, err}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {62'b0, strb, err}, (mon_e.kind == EV_STRB) ? 64'd2 : 64'd1);
        check("event_cr", cr, mon_e.cr);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts nbits of data (MSB first, zeros beyond bit 64) and checks the
  // readback bit before every rising sclk. abort_at >= 0 applies reset in
  // the middle of the frame. lat returns clocks from cs_n rising to the first
  // output pulse, or -1 if none appears.
  task automatic send_frame(input logic [63:0] data, input int nbits,
                            input int abort_at, output int lat);
    logic [63:0] rd;
    rd   = cr_model;
    lat  = -1;
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rstn = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(5);
        rstn = 1'b1;
        wait_clk(6);
        return;
      end
      mosi = (i < 64) ? data[63-i] : 1'b0;
      wait_clk(4);
      check($sformatf("miso_bit%0d", i), {63'b0, miso}, (i < 64) ? {63'b0, rd[63-i]} : 64'd0);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(5);
    cs_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (strb === 1'b1 || err === 1'b1) begin
        lat = c;
        break;
      end
    end
    wait_clk(6);
  endtask

  task automatic wait_events();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("pending_events", 64'(exp_q.size()), 64'd0);
  endtask

  // Full frame with expectation bookkeeping.
  task automatic frame(input logic [63:0] data, input int nbits, output int lat);
    ev_t e;
    if (nbits == 64) begin
      e.kind = EV_STRB; e.cr = data; exp_q.push_back(e);
    end else if (nbits != 0) begin
      e.kind = EV_ERR; e.cr = cr_model; exp_q.push_back(e);
    end
    send_frame(data, nbits, -1, lat);
    if (nbits == 64) cr_model = data;
    wait_events();
    check("cr_after_frame", cr, cr_model);
  endtask

  int lat;

  initial begin
    rstn = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cr_model = 64'h0;
    wait_clk(5);
    rstn = 1'b1;

    // 1: reset state holds quietly for 10 cycles
    for (int i = 0; i < 10; i++) begin
      check("reset_cr", cr, 64'h0);
      check("reset_pulses", {62'b0, strb, err}, 64'd0);
      wait_clk(1);
    end

    // 2: first commit, with strobe latency bounded after the sync chain
    frame(64'hE012_3456_789A_BCDE, 64, lat);
    check("strobe_latency_ok", 64'((lat >= SYNC + 1) && (lat <= SYNC + 2)), 64'd1);

    // 3: readback of E012... while writing zero
    frame(64'h0, 64, lat);

    // Non-zero word so the discarded frames must visibly leave it unchanged
    frame(64'h1234_5678_9ABC_DEF0, 64, lat);

    // 4: short frame then overrun frame
    frame(64'hFFFF_FFFF_FFFF_FFFF, 40, lat);
    frame(64'hDEAD_BEEF_0BAD_F00D, 65, lat);

    // 5: empty frame produces nothing
    frame(64'h0, 0, lat);
    check("empty_frame_no_event", 64'(lat < 0), 64'd1);

    // 6: reset after 30 bits aborts, then a clean commit
    send_frame(64'hFFFF_0000_FFFF_0000, 64, 30, lat);
    cr_model = 64'h0;
    check("abort_cr_reset", cr, 64'h0);
    check("abort_pulses", {62'b0, strb, err}, 64'd0);
    check("abort_no_pending", 64'(exp_q.size()), 64'd0);
    frame(64'hA5A5_A5A5_A5A5_A5A5, 64, lat);

    wait_clk(10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
